// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle RISC-V control FSM with memory handshake,
// watchdog, illegal-opcode trap and retired-instruction counter.
module mc_ctrl_fsm #(
  parameter int CNT_W        = 32,
  parameter int MEM_TIMEOUT  = 16,
  parameter int ILLEGAL_HALT = 1,
  parameter int EN_UTYPE     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_update,
  output logic             branch,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       imm_src,
  output logic             halted,
  output logic [1:0]       fault_code,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  // Numbering of the first eleven states matches the fixed-latency controller.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [3:0]        state;
  logic [3:0]        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        fault_next;
  logic              wd_hit;
  logic              mem_state;
  logic              utype_ok;

  logic mem_req_s, pc_update_s, branch_s, mem_write_s, ir_write_s;
  logic reg_write_s, retire_s;

  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign utype_ok  = (EN_UTYPE != 0);
  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign wd_hit    = (MEM_TIMEOUT != 0) && !mem_ready &&
                     (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next = state;
    fault_next = F_NONE;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (wd_hit) begin
          state_next = S_HALT;
          fault_next = F_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW, OP_JALR: state_next = S_MEMADR;
          OP_R:                  state_next = S_EXEC_R;
          OP_I:                  state_next = S_EXEC_I;
          OP_B:                  state_next = S_BRANCH;
          OP_JAL:                state_next = S_JAL;
          OP_LUI:                state_next = utype_ok ? S_LUI : S_HALT;
          OP_AUIPC:              state_next = utype_ok ? S_ALUWB : S_HALT;
          default:               state_next = S_HALT;
        endcase
        if (state_next == S_HALT) begin
          if (ILLEGAL_HALT != 0) begin
            fault_next = F_ILLEGAL;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_MEMADR: begin
        if (op == OP_JALR)  state_next = S_JAL;
        else if (op[5])     state_next = S_MEMWRITE;
        else                state_next = S_MEMREAD;
      end
      S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) begin
          state_next = (state == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (wd_hit) begin
          state_next = S_HALT;
          fault_next = F_TIMEOUT;
        end
      end
      S_MEMWB, S_ALUWB, S_BRANCH:    state_next = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_LUI:     state_next = S_ALUWB;
      S_JAL:                         state_next = S_ALUWB;
      S_HALT:                        state_next = S_HALT;
      default:                       state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      fault_code <= F_NONE;
      instret    <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || mem_ready) begin
        wait_cnt <= '0;
      end else if (mem_state) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (fault_next != F_NONE) begin
        fault_code <= fault_next;
      end
      if (retire_s) begin
        instret <= instret + 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_s   = 1'b0;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    retire_s    = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_op      = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req_s   = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write_s  = mem_ready;
        pc_update_s = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        retire_s    = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      // PC takes the target held in ALUOut; ALUResult carries the link value.
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        pc_update_s = 1'b1;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch_s  = 1'b1;
        retire_s  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_SW:            imm_src = 3'b001;
      OP_B:             imm_src = 3'b010;
      OP_JAL:           imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = utype_ok ? 3'b100 : 3'b000;
      default:          imm_src = 3'b000;
    endcase
  end

  // Strobes are gated so they drop the instant reset is asserted.
  assign mem_req   = rst_n & mem_req_s;
  assign pc_update = rst_n & pc_update_s;
  assign branch    = rst_n & branch_s;
  assign mem_write = rst_n & mem_write_s;
  assign ir_write  = rst_n & ir_write_s;
  assign reg_write = rst_n & reg_write_s;
  assign retire    = rst_n & retire_s;
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm.
module tb_mc_ctrl_fsm;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, JALR = 7'b1100111;
  localparam logic [6:0] RT = 7'b0110011, IT = 7'b0010011, BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  // {mem_req,pc_update,ir_write,adr_src,mem_write,reg_write,branch,retire,halted}
  //  _result_src_alu_op_alu_src_a_alu_src_b
  localparam logic [16:0] C_RESET     = 17'b000000000_10_00_00_10;
  localparam logic [16:0] C_FETCH_RDY = 17'b111000000_10_00_00_10;
  localparam logic [16:0] C_FETCH_W   = 17'b100000000_10_00_00_10;
  localparam logic [16:0] C_DECODE    = 17'b000000000_00_00_01_01;
  localparam logic [16:0] C_MEMADR    = 17'b000000000_00_00_10_01;
  localparam logic [16:0] C_MEMREAD   = 17'b100100000_00_00_00_00;
  localparam logic [16:0] C_MEMWB     = 17'b000001010_01_00_00_00;
  localparam logic [16:0] C_MEMWR_W   = 17'b100110000_00_00_00_00;
  localparam logic [16:0] C_MEMWR_RDY = 17'b100110010_00_00_00_00;
  localparam logic [16:0] C_EXEC_R    = 17'b000000000_00_10_10_00;
  localparam logic [16:0] C_EXEC_I    = 17'b000000000_00_10_10_01;
  localparam logic [16:0] C_LUI       = 17'b000000000_00_00_11_01;
  localparam logic [16:0] C_JAL       = 17'b010000000_00_00_01_10;
  localparam logic [16:0] C_ALUWB     = 17'b000001010_00_00_00_00;
  localparam logic [16:0] C_BRANCH    = 17'b000000110_00_01_10_00;
  localparam logic [16:0] C_HALT      = 17'b000000001_00_00_00_00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;

  logic       mem_req_a, pc_update_a, branch_a, adr_src_a, mem_write_a, ir_write_a;
  logic       reg_write_a, halted_a, retire_a;
  logic [1:0] result_src_a, alu_op_a, src_a_a, src_b_a, fault_a;
  logic [2:0] imm_src_a;
  logic [3:0] instret_a;

  logic       mem_req_b, pc_update_b, branch_b, adr_src_b, mem_write_b, ir_write_b;
  logic       reg_write_b, halted_b, retire_b;
  logic [1:0] result_src_b, alu_op_b, src_a_b, src_b_b, fault_b;
  logic [2:0] imm_src_b;
  logic [31:0] instret_b;

  mc_ctrl_fsm #(.CNT_W(4), .MEM_TIMEOUT(4), .ILLEGAL_HALT(1), .EN_UTYPE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req_a), .pc_update(pc_update_a), .branch(branch_a), .adr_src(adr_src_a),
    .mem_write(mem_write_a), .ir_write(ir_write_a), .reg_write(reg_write_a),
    .result_src(result_src_a), .alu_op(alu_op_a), .alu_src_a(src_a_a), .alu_src_b(src_b_a),
    .imm_src(imm_src_a), .halted(halted_a), .fault_code(fault_a), .retire(retire_a),
    .instret(instret_a)
  );

  mc_ctrl_fsm #(.CNT_W(32), .MEM_TIMEOUT(16), .ILLEGAL_HALT(0), .EN_UTYPE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .pc_update(pc_update_b), .branch(branch_b), .adr_src(adr_src_b),
    .mem_write(mem_write_b), .ir_write(ir_write_b), .reg_write(reg_write_b),
    .result_src(result_src_b), .alu_op(alu_op_b), .alu_src_a(src_a_b), .alu_src_b(src_b_b),
    .imm_src(imm_src_b), .halted(halted_b), .fault_code(fault_b), .retire(retire_b),
    .instret(instret_b)
  );

  logic [16:0] ctl_a, ctl_b;
  assign ctl_a = {mem_req_a, pc_update_a, ir_write_a, adr_src_a, mem_write_a, reg_write_a,
                  branch_a, retire_a, halted_a, result_src_a, alu_op_a, src_a_a, src_b_a};
  assign ctl_b = {mem_req_b, pc_update_b, ir_write_b, adr_src_b, mem_write_b, reg_write_b,
                  branch_b, retire_b, halted_b, result_src_b, alu_op_b, src_a_b, src_b_b};

  int n_checks = 0;
  int n_errors = 0;
  int retire_seen = 0;
  int r0;

  always @(posedge clk) if (retire_a === 1'b1) retire_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [6:0] o, input logic rdy,
                     input logic [16:0] exp);
    @(negedge clk);
    rst_n = 1'b1;
    op = o;
    mem_ready = rdy;
    #1;
    check(tag, 32'(ctl_a), 32'(exp));
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_ctl", 32'(ctl_a), 32'(C_RESET));
    repeat (n) @(negedge clk);
    #1;
    check("rst_instret", 32'(instret_a), 32'd0);
    check("rst_fault", 32'(fault_a), 32'd0);
  endtask

  initial begin
    op = 7'd0;
    funct3 = 3'd0;
    mem_ready = 1'b1;
    hold_reset(2);

    cyc("addi_f", IT, 1, C_FETCH_RDY); cyc("addi_d", IT, 1, C_DECODE);
    cyc("addi_x", IT, 1, C_EXEC_I);    cyc("addi_wb", IT, 1, C_ALUWB);
    cyc("add_f", RT, 1, C_FETCH_RDY);  cyc("add_d", RT, 1, C_DECODE);
    check("imm_r", 32'(imm_src_a), 32'd0);
    cyc("add_x", RT, 1, C_EXEC_R);     cyc("add_wb", RT, 1, C_ALUWB);
    cyc("sw_f", SW, 1, C_FETCH_RDY);   cyc("sw_d", SW, 1, C_DECODE);
    check("imm_s", 32'(imm_src_a), 32'd1);
    cyc("sw_a", SW, 1, C_MEMADR);      cyc("sw_w", SW, 1, C_MEMWR_RDY);
    cyc("lw_f", LW, 1, C_FETCH_RDY);   cyc("lw_d", LW, 1, C_DECODE);
    cyc("lw_a", LW, 1, C_MEMADR);      cyc("lw_r", LW, 1, C_MEMREAD);
    cyc("lw_wb", LW, 1, C_MEMWB);
    cyc("beq_f", BEQ, 1, C_FETCH_RDY); cyc("beq_d", BEQ, 1, C_DECODE);
    check("imm_b", 32'(imm_src_a), 32'd2);
    cyc("beq_br", BEQ, 1, C_BRANCH);

    // lw with three wait cycles; ready lands exactly at the watchdog limit
    cyc("lww_f", LW, 1, C_FETCH_RDY);
    check("instret_prog", 32'(instret_a), 32'd5);
    check("retire_prog", 32'(retire_seen), 32'd5);
    cyc("lww_d", LW, 1, C_DECODE);     cyc("lww_a", LW, 1, C_MEMADR);
    for (int i = 0; i < 3; i++) cyc("lww_wait", LW, 0, C_MEMREAD);
    cyc("lww_rdy", LW, 1, C_MEMREAD);  cyc("lww_wb", LW, 1, C_MEMWB);

    cyc("lui_f", LUI, 1, C_FETCH_RDY); cyc("lui_d", LUI, 1, C_DECODE);
    check("imm_lui", 32'(imm_src_a), 32'd4);
    check("instret_lww", 32'(instret_a), 32'd6);
    cyc("lui_x", LUI, 1, C_LUI);       cyc("lui_wb", LUI, 1, C_ALUWB);
    cyc("aui_f", AUIPC, 1, C_FETCH_RDY); cyc("aui_d", AUIPC, 1, C_DECODE);
    check("imm_auipc", 32'(imm_src_a), 32'd4);
    cyc("aui_wb", AUIPC, 1, C_ALUWB);
    cyc("jal_f", JAL, 1, C_FETCH_RDY); cyc("jal_d", JAL, 1, C_DECODE);
    check("imm_jal", 32'(imm_src_a), 32'd3);
    cyc("jal_j", JAL, 1, C_JAL);       cyc("jal_wb", JAL, 1, C_ALUWB);
    cyc("jalr_f", JALR, 1, C_FETCH_RDY); cyc("jalr_d", JALR, 1, C_DECODE);
    check("imm_jalr", 32'(imm_src_a), 32'd0);
    cyc("jalr_a", JALR, 1, C_MEMADR);  cyc("jalr_j", JALR, 1, C_JAL);
    cyc("jalr_wb", JALR, 1, C_ALUWB);

    // memory never answers in FETCH: four wait cycles then HALT
    for (int i = 0; i < 4; i++) cyc("wd_fetch", IT, 0, C_FETCH_W);
    check("instret_u", 32'(instret_a), 32'd10);
    cyc("wd_halt", IT, 0, C_HALT);
    check("wd_fault", 32'(fault_a), 32'd2);
    cyc("wd_halt_stay", IT, 1, C_HALT);
    check("wd_fault_sticky", 32'(fault_a), 32'd2);

    @(negedge clk);
    hold_reset(1);
    cyc("ill_f", 7'd0, 1, C_FETCH_RDY); cyc("ill_d", 7'd0, 1, C_DECODE);
    check("imm_ill", 32'(imm_src_a), 32'd0);
    cyc("ill_halt", 7'd0, 1, C_HALT);
    check("ill_fault", 32'(fault_a), 32'd1);
    check("nop_ctl", 32'(ctl_b), 32'(C_FETCH_RDY));
    check("nop_fault", 32'(fault_b), 32'd0);
    check("nop_instret", instret_b, 32'd0);

    // reset dropped between clock edges while a store waits for memory
    @(negedge clk);
    hold_reset(1);
    cyc("swr_f", SW, 1, C_FETCH_RDY);  cyc("swr_d", SW, 1, C_DECODE);
    cyc("swr_a", SW, 1, C_MEMADR);     cyc("swr_w", SW, 0, C_MEMWR_W);
    #2;
    hold_reset(1);

    r0 = retire_seen;
    for (int i = 0; i < 17; i++) begin
      cyc("wrap_f", BEQ, 1, C_FETCH_RDY);
      cyc("wrap_d", BEQ, 1, C_DECODE);
      cyc("wrap_br", BEQ, 1, C_BRANCH);
    end
    cyc("wrap_end", IT, 1, C_FETCH_RDY);
    check("instret_wrap", 32'(instret_a), 32'd1);
    check("retire_wrap", 32'(retire_seen - r0), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
